brightness_ctrl: RTL and testbench

- Frame-synchronous controller that owns the brightness stage's `en_bp` and `brightness_param` inputs.
- Holds host configuration in shadow registers and commits it only at end-of-frame, so a frame never mixes two parameter values.
- In auto mode it measures mean luma of the stage's input, then steps the parameter toward a target once per frame, rate-limited and saturated.
- Sits beside the brightness stage and taps the same `color_in`, `color_in_valid` and `datapath_ready` signals.

---
 rtl/brightness_ctrl_pkg.sv | 41 ++++
 rtl/brightness_ctrl_luma.sv | 49 ++++
 rtl/brightness_ctrl.sv | 179 +++++++++++++++++
 tb/tb_brightness_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_ctrl_pkg.sv
// Shared types and constants for the brightness stage and its frame controller.
package brightness_ctrl_pkg;

    typedef logic [7:0]        color_t;
    typedef logic signed [8:0] color_signed_t;

    localparam color_t MIN_COLOR = 8'd0;
    localparam color_t MAX_COLOR = 8'd255;

    // Legal range of the brightness offset applied by the stage
    localparam int MIN_PARAM = -255;
    localparam int MAX_PARAM = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } bctrl_state_t;

    // One complete host configuration; moved as a unit from shadow to active
    typedef struct packed {
        logic          en;
        logic          auto_en;
        color_signed_t param;
        color_t        target;
        color_t        step;
    } bctrl_cfg_t;

    // Clamp a 10-bit signed sum into the legal parameter range
    function automatic color_signed_t sat_param(input logic signed [9:0] v);
        if (v > 10'(MAX_PARAM)) begin
            return color_signed_t'(MAX_PARAM);
        end else if (v < 10'(MIN_PARAM)) begin
            return color_signed_t'(MIN_PARAM);
        end else begin
            return v[8:0];
        end
    endfunction

endpackage

// File: rtl/brightness_ctrl_luma.sv
// Luma accumulator: sums the first 2^LOG2_SAMPLES accepted pixels of a frame.
// 'clear' restarts the sum with the current pixel (the sof pixel counts),
// 'add' accumulates the current pixel. 'last_sample' flags the pixel that
// completes the quota, in the same cycle it is presented.
module luma_accum
    import brightness_ctrl_pkg::*;
#(
    parameter int LOG2_SAMPLES = 4,
    parameter int ACC_W        = 8 + LOG2_SAMPLES
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             add,
    input  color_t           pixel,
    output logic [ACC_W-1:0] acc_sum,
    output logic             last_sample
);

    localparam int                CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0]  QUOTA = CNT_W'(2 ** LOG2_SAMPLES);

    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count after this pixel, and whether it completes the quota
    always_comb begin
        cnt_next    = clear ? CNT_W'(1) : cnt_reg + CNT_W'(1);
        last_sample = (clear | add) && (cnt_next == QUOTA);
    end

    // Sum and counter; only move on a qualified pixel
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clear) begin
            acc_reg <= ACC_W'(pixel);
            cnt_reg <= cnt_next;
        end else if (add) begin
            acc_reg <= acc_reg + ACC_W'(pixel);
            cnt_reg <= cnt_next;
        end
    end

    assign acc_sum = acc_reg;

endmodule

// File: rtl/brightness_ctrl.sv
// Frame-synchronous controller for the brightness stage. Host writes land in a
// shadow copy and are committed only at an accepted end-of-frame, so a frame
// never sees two parameter values. In auto mode the mean luma of the first
// pixels of a frame drives a rate-limited, saturated step toward a target.
module brightness_ctrl
    import brightness_ctrl_pkg::*;
#(
    parameter int LOG2_SAMPLES = 4,
    parameter int ACC_W        = 8 + LOG2_SAMPLES
) (
    input  logic          clk,
    input  logic          resetN,
    input  color_t        color_in,
    input  logic          color_in_valid,
    input  logic          datapath_ready,
    input  logic          sof,
    input  logic          eof,
    input  logic          cfg_wr,
    input  logic          cfg_en,
    input  logic          cfg_auto,
    input  color_signed_t cfg_param,
    input  color_t        cfg_target,
    input  color_t        cfg_step,
    output logic          en_bp,
    output color_signed_t brightness_param,
    output logic          param_update,
    output color_t        avg_luma,
    output logic          auto_busy,
    output logic          short_frame
);

    logic accept, sof_acc, eof_acc, pend_commit;
    logic acc_clear, acc_add, last_sample;
    logic [ACC_W-1:0] acc_sum;

    bctrl_state_t  state_reg, state_next;
    bctrl_cfg_t    shadow_reg, shadow_next;
    bctrl_cfg_t    active_reg, active_next;
    logic          pending_reg, pending_next;
    color_signed_t result_reg, result_next, result_calc;
    color_t        avg_reg, avg_next, avg_calc;
    logic          update_reg, update_next;
    logic          short_reg, short_next;

    logic [ACC_W-1:0]   acc_shr;
    logic signed [9:0]  err_raw, step_s, err_clamped, param_sum;

    assign accept      = color_in_valid & datapath_ready;
    assign sof_acc     = sof & accept;
    assign eof_acc     = eof & accept;
    // A pending host commit overrides everything else at end-of-frame
    assign pend_commit = eof_acc & pending_reg;
    assign acc_clear   = !pend_commit && (state_reg == IDLE) && sof_acc
                         && active_reg.auto_en && active_reg.en;
    assign acc_add     = !pend_commit && (state_reg == SAMPLE) && accept;

    luma_accum #(
        .LOG2_SAMPLES (LOG2_SAMPLES),
        .ACC_W        (ACC_W)
    ) u_luma (
        .clk         (clk),
        .resetN      (resetN),
        .clear       (acc_clear),
        .add         (acc_add),
        .pixel       (color_in),
        .acc_sum     (acc_sum),
        .last_sample (last_sample)
    );

    // Mean, clamped error and saturated new parameter (used in CALC)
    always_comb begin
        acc_shr  = acc_sum >> LOG2_SAMPLES;
        avg_calc = acc_shr[7:0];
        err_raw  = $signed({2'b00, active_reg.target}) - $signed({2'b00, avg_calc});
        step_s   = $signed({2'b00, active_reg.step});
        err_clamped = err_raw;
        if (err_raw > step_s) begin
            err_clamped = step_s;
        end else if (err_raw < -step_s) begin
            err_clamped = -step_s;
        end
        param_sum   = $signed({active_reg.param[8], active_reg.param}) + err_clamped;
        result_calc = sat_param(param_sum);
    end

    // FSM, shadow/active registers and commit priority
    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        result_next  = result_reg;
        avg_next     = avg_reg;
        short_next   = 1'b0;

        if (pend_commit) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
            state_next   = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (acc_clear) begin
                        if (last_sample) begin
                            state_next = CALC;
                        end else if (eof_acc) begin
                            short_next = 1'b1;
                        end else begin
                            state_next = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (acc_add) begin
                        if (last_sample) begin
                            state_next = CALC;
                        end else if (eof_acc) begin
                            state_next = IDLE;
                            short_next = 1'b1;
                        end
                    end
                end
                CALC: begin
                    avg_next    = avg_calc;
                    result_next = result_calc;
                    state_next  = DONE;
                end
                DONE: begin
                    if (eof_acc) begin
                        active_next.param = result_reg;
                        state_next        = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // A write in the commit cycle is held for the following end-of-frame
        if (cfg_wr) begin
            shadow_next = '{en: cfg_en, auto_en: cfg_auto, param: cfg_param,
                            target: cfg_target, step: cfg_step};
            pending_next = 1'b1;
        end

        update_next = (active_next.en != active_reg.en) ||
                      (active_next.param != active_reg.param);
    end

    // State registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            result_reg  <= '0;
            avg_reg     <= '0;
            update_reg  <= 1'b0;
            short_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            result_reg  <= result_next;
            avg_reg     <= avg_next;
            update_reg  <= update_next;
            short_reg   <= short_next;
        end
    end

    assign en_bp            = active_reg.en;
    assign brightness_param = active_reg.param;
    assign param_update     = update_reg;
    assign avg_luma         = avg_reg;
    assign auto_busy        = (state_reg != IDLE);
    assign short_frame      = short_reg;

endmodule

// File: tb/tb_brightness_ctrl.sv
// Randomised bench for brightness_ctrl against a frame-level reference model.
module tb_brightness_ctrl;
    import brightness_ctrl_pkg::*;

    localparam int LOG2 = 4;
    localparam int N    = 1 << LOG2;

    logic          clk = 1'b0;
    logic          resetN;
    color_t        color_in;
    logic          color_in_valid, datapath_ready, sof, eof;
    logic          cfg_wr, cfg_en, cfg_auto;
    color_signed_t cfg_param;
    color_t        cfg_target, cfg_step;
    logic          en_bp, param_update, auto_busy, short_frame;
    color_signed_t brightness_param;
    color_t        avg_luma;

    brightness_ctrl #(.LOG2_SAMPLES(LOG2)) dut (
        .clk(clk), .resetN(resetN), .color_in(color_in),
        .color_in_valid(color_in_valid), .datapath_ready(datapath_ready),
        .sof(sof), .eof(eof), .cfg_wr(cfg_wr), .cfg_en(cfg_en),
        .cfg_auto(cfg_auto), .cfg_param(cfg_param), .cfg_target(cfg_target),
        .cfg_step(cfg_step), .en_bp(en_bp), .brightness_param(brightness_param),
        .param_update(param_update), .avg_luma(avg_luma),
        .auto_busy(auto_busy), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_no = 0;

    // Reference model: active and shadow configuration, collected samples
    int m_en, m_auto, m_param, m_target, m_step;
    int s_en, s_auto, s_param, s_target, s_step;
    int m_pend, m_sampling, m_calc, m_have, m_res, m_avg, m_upd, m_short;
    int samples[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_param = 0; m_target = 0; m_step = 0;
        s_en = 0; s_auto = 0; s_param = 0; s_target = 0; s_step = 0;
        m_pend = 0; m_sampling = 0; m_calc = 0; m_have = 0; m_res = 0;
        m_avg = 0; m_upd = 0; m_short = 0;
        samples.delete();
    endtask

    // One clock of the frame-level rules, using the inputs seen at the edge
    task automatic model_step();
        bit acc, eofa, sofa;
        int old_en, old_param, sum, err, r;
        acc  = color_in_valid && datapath_ready;
        eofa = acc && eof;
        sofa = acc && sof;
        old_en = m_en; old_param = m_param;
        m_short = 0;
        if (eofa && m_pend != 0) begin
            m_en = s_en; m_auto = s_auto; m_param = s_param;
            m_target = s_target; m_step = s_step;
            m_pend = 0; m_sampling = 0; m_calc = 0; m_have = 0;
            samples.delete();
        end else if (m_calc != 0) begin
            sum = 0;
            foreach (samples[i]) sum += samples[i];
            m_avg = sum / N;
            err = m_target - m_avg;
            if (err > m_step) err = m_step;
            if (err < -m_step) err = -m_step;
            r = m_param + err;
            if (r > 255) r = 255;
            if (r < -255) r = -255;
            m_res = r; m_calc = 0; m_have = 1;
        end else if (m_have != 0) begin
            if (eofa) begin
                m_param = m_res;
                m_have = 0;
            end
        end else if (m_sampling != 0) begin
            if (acc) begin
                samples.push_back(int'(color_in));
                if (samples.size() == N) begin
                    m_sampling = 0; m_calc = 1;
                end else if (eofa) begin
                    m_sampling = 0; m_short = 1;
                end
            end
        end else if (sofa && m_auto != 0 && m_en != 0) begin
            samples.delete();
            samples.push_back(int'(color_in));
            if (samples.size() == N) m_calc = 1;
            else if (eofa) m_short = 1;
            else m_sampling = 1;
        end
        if (cfg_wr) begin
            s_en = int'(cfg_en); s_auto = int'(cfg_auto); s_param = int'(cfg_param);
            s_target = int'(cfg_target); s_step = int'(cfg_step);
            m_pend = 1;
        end
        m_upd = (m_en != old_en || m_param != old_param) ? 1 : 0;
    endtask

    // Advance one clock, update the model, compare every output
    task automatic tick();
        @(posedge clk);
        if (!resetN) model_reset();
        else model_step();
        #1;
        cfg_wr = 1'b0;
        check("en_bp", int'(en_bp), m_en);
        check("brightness_param", int'(brightness_param), m_param);
        check("param_update", int'(param_update), m_upd);
        check("avg_luma", int'(avg_luma), m_avg);
        check("auto_busy", int'(auto_busy), (m_sampling | m_calc | m_have) != 0 ? 1 : 0);
        check("short_frame", int'(short_frame), m_short);
    endtask

    task automatic set_cfg(input bit en, input bit au, input int p, input int t, input int st);
        cfg_en = en; cfg_auto = au; cfg_param = color_signed_t'(p);
        cfg_target = color_t'(t); cfg_step = color_t'(st);
    endtask

    task automatic write_cfg(input bit en, input bit au, input int p, input int t, input int st);
        set_cfg(en, au, p, t, st);
        cfg_wr = 1'b1;
        tick();
    endtask

    // Present one pixel until it is accepted; optional forced stall first
    task automatic send_pixel(input bit s, input bit e, input int pix,
                              input int stall, input bit wr_now);
        bit rdy;
        color_in_valid = 1'b1; sof = s; eof = e; color_in = color_t'(pix);
        for (int c = 0; c < 100; c++) begin
            if (wr_now) rdy = 1'b1;
            else if (c < stall) rdy = 1'b0;
            else if (c >= stall + 8) rdy = 1'b1;
            else rdy = ($urandom_range(3) != 0);
            datapath_ready = rdy;
            if (wr_now) cfg_wr = 1'b1;
            tick();
            if (rdy) break;
        end
        color_in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input int spread,
                              input int wr_at, input bit wr_on_eof, input int eof_stall);
        int v;
        for (int i = 0; i < len; i++) begin
            v = base;
            if (spread > 0) v = base + int'($urandom_range(2 * spread)) - spread;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            if (i == wr_at) cfg_wr = 1'b1;
            send_pixel(i == 0, i == len - 1, v,
                       (i == len - 1) ? eof_stall : 0, (i == len - 1) && wr_on_eof);
            if (i < len - 1 && $urandom_range(3) == 0) begin
                color_in = color_t'($urandom_range(255));
                datapath_ready = $urandom_range(1) != 0;
                tick();
            end
        end
        frame_no++;
        $display("[TB] frame %0d len=%0d base=%0d en=%0d param=%0d avg=%0d short=%0d",
                 frame_no, len, base, en_bp, brightness_param, avg_luma, short_frame);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, wr_at;
        resetN = 1'b0; color_in = '0; color_in_valid = 1'b0; datapath_ready = 1'b0;
        sof = 1'b0; eof = 1'b0; cfg_wr = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("reset_en", int'(en_bp), 0);
        check("reset_param", int'(brightness_param), 0);
        tick(); tick();
        resetN = 1'b1;
        tick();

        // Manual commit: write mid-frame, visible only after eof
        set_cfg(1, 0, 40, 0, 0);
        send_frame(12, 80, 10, 5, 1'b0, 0);
        check("manual_en", int'(en_bp), 1);
        check("manual_param", int'(brightness_param), 40);
        check("manual_update", int'(param_update), 1);
        tick();
        check("manual_update_pulse", int'(param_update), 0);

        // Auto step toward target, rate-limited to 8 per frame
        write_cfg(1, 1, 0, 128, 8);
        send_frame(20, 100, 0, -1, 1'b0, 0);
        check("auto_commit_param", int'(brightness_param), 0);
        send_frame(20, 100, 0, -1, 1'b0, 0);
        check("auto_avg", int'(avg_luma), 100);
        check("auto_step1", int'(brightness_param), 8);
        send_frame(20, 100, 0, -1, 1'b0, 0);
        check("auto_step2", int'(brightness_param), 16);

        // Saturation in both directions
        write_cfg(1, 1, 250, 255, 16);
        send_frame(8, 50, 0, -1, 1'b0, 0);
        send_frame(20, 0, 0, -1, 1'b0, 0);
        check("sat_pos", int'(brightness_param), 255);
        write_cfg(1, 1, -250, 0, 16);
        send_frame(8, 50, 0, -1, 1'b0, 0);
        send_frame(20, 255, 0, -1, 1'b0, 0);
        check("sat_neg", int'(brightness_param), -255);

        // Short frame: eof after 10 samples
        write_cfg(1, 1, 0, 128, 8);
        send_frame(8, 50, 0, -1, 1'b0, 0);
        send_frame(10, 100, 0, -1, 1'b0, 0);
        check("short_pulse", int'(short_frame), 1);
        check("short_busy", int'(auto_busy), 0);
        check("short_param", int'(brightness_param), 0);

        // Stalled eof, then a write colliding with the eof accept
        send_frame(20, 100, 0, -1, 1'b0, 5);
        check("stall_param", int'(brightness_param), 8);
        set_cfg(1, 0, -77, 0, 0);
        send_frame(20, 100, 0, -1, 1'b1, 0);
        check("collide_deferred", int'(brightness_param), 16);
        send_frame(6, 30, 0, -1, 1'b0, 0);
        check("collide_commit", int'(brightness_param), -77);

        // Reset in the middle of traffic takes effect immediately
        for (int i = 0; i < 8; i++) send_pixel(i == 0, 1'b0, 90, 0, 1'b0);
        #3;
        resetN = 1'b0;
        #1;
        check("midrst_en", int'(en_bp), 0);
        check("midrst_param", int'(brightness_param), 0);
        check("midrst_busy", int'(auto_busy), 0);
        check("midrst_avg", int'(avg_luma), 0);
        model_reset();
        tick(); tick();
        resetN = 1'b1;
        tick();

        // Random traffic with random configuration writes
        write_cfg(1, 1, int'($urandom_range(100)) - 50, $urandom_range(255), $urandom_range(1, 40));
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(6, 30));
            wr_at = -1;
            if ($urandom_range(4) == 0) begin
                wr_at = int'($urandom_range(len - 1));
                set_cfg($urandom_range(5) != 0, $urandom_range(4) != 0,
                        int'($urandom_range(510)) - 255, $urandom_range(255),
                        $urandom_range(64));
            end
            send_frame(len, int'($urandom_range(255)), 30, wr_at,
                       (wr_at < 0) && ($urandom_range(9) == 0), int'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
